// File: rtl/param_fifo.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow flags, synchronous flush and standard or FWFT read port.
module param_fifo #(
  parameter int DATA_W    = 11,
  parameter int ADDR_W    = 4,
  parameter int FWFT      = 0,
  parameter int AFULL_TH  = 14,
  parameter int AEMPTY_TH = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_flush,
  input  logic              i_clear_err,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_write,
  input  logic              i_read,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_empty,
  output logic              o_full,
  output logic              o_almost_empty,
  output logic              o_almost_full,
  output logic [ADDR_W:0]   o_count,
  output logic              o_overflow,
  output logic              o_underflow
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_C  = (ADDR_W+1)'(AFULL_TH);
  localparam logic [ADDR_W:0] AEMPTY_C = (ADDR_W+1)'(AEMPTY_TH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count;
  logic              wr_acc, rd_acc, ovf_evt, unf_evt;

  assign o_count        = count;
  assign o_empty        = (count == '0);
  assign o_full         = (count == DEPTH_C);
  assign o_almost_empty = (count <= AEMPTY_C);
  assign o_almost_full  = (count >= AFULL_C);

  // Flush overrides any read/write in the same cycle, so nothing is accepted or flagged.
  assign rd_acc  = i_read & ~o_empty & ~i_flush;
  assign wr_acc  = i_write & (~o_full | rd_acc) & ~i_flush;
  assign ovf_evt = i_write & o_full & ~(i_read & ~o_empty) & ~i_flush;
  assign unf_evt = i_read & o_empty & ~i_flush;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Set wins over a simultaneous clear.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      o_overflow  <= (o_overflow  & ~i_clear_err) | ovf_evt;
      o_underflow <= (o_underflow & ~i_clear_err) | unf_evt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_acc) mem[wr_ptr] <= i_data;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word shown directly; zero while empty so reset/empty output is defined.
      assign o_data  = o_empty ? '0 : mem[rd_ptr];
      assign o_valid = ~o_empty;
    end else begin : g_std
      logic [DATA_W-1:0] rd_data;
      logic              rd_vld;
      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
          rd_data <= '0;
          rd_vld  <= 1'b0;
        end else begin
          rd_vld <= rd_acc;
          if (rd_acc) rd_data <= mem[rd_ptr];
        end
      end
      assign o_data  = rd_data;
      assign o_valid = rd_vld;
    end
  endgenerate
endmodule
